regfile_ctrl: RTL and testbench

Sequencer and arbiter placed in front of the 32×32 register file (two read ports A/B, one write port). After reset, its INIT sweep writes zero to all 32 entries, because the SRAM powers up undefined. In RUN it does four things: shares the single write port between core writeback and the debug port, serves debug reads through read port B by stalling the core, suppresses writes to x0, and forwards same-cycle write data to the core read outputs.

---
 rtl/regfile_ctrl.sv | 171 +++++++++++++++++
 tb/tb_regfile_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_ctrl.sv
// Front-end sequencer for a 32x32 register file: zeroing sweep after reset, write-port
// arbitration between core writeback and debug, debug reads via port B, x0 and forwarding.
module regfile_ctrl #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      ra,
  input  logic [4:0]      rb,
  output logic [XLEN-1:0] qa,
  output logic [XLEN-1:0] qb,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            wb_ready,
  output logic            stall,
  input  logic            dbg_req,
  input  logic            dbg_we,
  input  logic [4:0]      dbg_addr,
  input  logic [XLEN-1:0] dbg_wdata,
  output logic            dbg_ack,
  output logic [XLEN-1:0] dbg_rdata,
  output logic            init_done,
  output logic [4:0]      rf_ra,
  output logic [4:0]      rf_rb,
  output logic [4:0]      rf_rd,
  output logic [XLEN-1:0] rf_di,
  output logic            rf_we,
  input  logic [XLEN-1:0] rf_qa,
  input  logic [XLEN-1:0] rf_qb
);

  localparam int unsigned SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  localparam logic [1:0] ST_INIT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DBG  = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [4:0]      ic_q, ic_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic            init_done_q, init_done_d;
  logic [XLEN-1:0] dbg_rdata_q, dbg_rdata_d;

  logic            dbg_grant;
  logic            dbg_wr_grant;
  logic            dbg_rd_grant;
  logic            wb_win;
  logic [4:0]      wr_addr;
  logic [XLEN-1:0] wr_data;
  logic            wr_en;

  // Debug only gets the port when writeback is idle or it has waited long enough.
  always_comb begin
    dbg_grant    = (state_q == ST_RUN) && dbg_req &&
                   (!wb_valid || (starve_q == STARVE_MAX));
    dbg_wr_grant = dbg_grant && dbg_we;
    dbg_rd_grant = dbg_grant && !dbg_we;
    wb_win       = (state_q != ST_INIT) && wb_valid && !dbg_wr_grant;
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = wb_rd;
    wr_data = wb_data;
    case (state_q)
      ST_INIT: begin
        wr_en   = 1'b1;
        wr_addr = ic_q;
        wr_data = '0;
      end
      ST_RUN: begin
        if (dbg_wr_grant) begin
          wr_addr = dbg_addr;
          wr_data = dbg_wdata;
        end
        // Writes to x0 are accepted but never reach the array.
        wr_en = (wb_win || dbg_wr_grant) && (wr_addr != 5'd0);
      end
      ST_DBG: begin
        wr_en = wb_win && (wb_rd != 5'd0);
      end
      default: begin
        wr_en = 1'b0;
      end
    endcase
  end

  always_comb begin
    rf_ra    = ra;
    rf_rb    = dbg_rd_grant ? dbg_addr : rb;
    rf_rd    = wr_addr;
    rf_di    = wr_data;
    rf_we    = wr_en;
    wb_ready = wb_win;
    stall    = (state_q == ST_INIT) || dbg_grant;
    dbg_ack  = (state_q == ST_DBG);
    dbg_rdata = dbg_rdata_q;
    init_done = init_done_q;
  end

  always_comb begin
    if (ra == 5'd0) begin
      qa = '0;
    end else if (wr_en && (wr_addr == ra)) begin
      qa = wr_data;
    end else begin
      qa = rf_qa;
    end
    if (rb == 5'd0) begin
      qb = '0;
    end else if (wr_en && (wr_addr == rb)) begin
      qb = wr_data;
    end else begin
      qb = rf_qb;
    end
  end

  always_comb begin
    state_d     = state_q;
    ic_d        = ic_q;
    starve_d    = starve_q;
    init_done_d = init_done_q;
    dbg_rdata_d = dbg_rdata_q;
    case (state_q)
      ST_INIT: begin
        ic_d = ic_q + 5'd1;
        if (ic_q == 5'd31) begin
          state_d     = ST_RUN;
          init_done_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (dbg_grant) begin
          state_d  = ST_DBG;
          starve_d = '0;
          if (!dbg_we) begin
            dbg_rdata_d = (dbg_addr == 5'd0) ? '0 : rf_qb;
          end
        end else if (dbg_req && (starve_q != STARVE_MAX)) begin
          starve_d = starve_q + SW'(1);
        end
      end
      ST_DBG: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_INIT;
      ic_q        <= '0;
      starve_q    <= '0;
      init_done_q <= 1'b0;
      dbg_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      ic_q        <= ic_d;
      starve_q    <= starve_d;
      init_done_q <= init_done_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

endmodule

// File: tb/tb_regfile_ctrl.sv
// Self-checking bench for regfile_ctrl: an array-backed register file plus an
// architectural model of what the core and debugger should observe each cycle.
module tb_regfile_ctrl;
  localparam int XLEN  = 32;
  localparam int LIMIT = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [4:0]      ra, rb, wb_rd, dbg_addr, rf_ra, rf_rb, rf_rd;
  logic [XLEN-1:0] qa, qb, wb_data, dbg_wdata, dbg_rdata, rf_di, rf_qa, rf_qb;
  logic            wb_valid, wb_ready, stall, dbg_req, dbg_we, dbg_ack, init_done, rf_we;
  logic            ovr_a = 1'b0;

  logic [XLEN-1:0] mem [32];

  regfile_ctrl #(.XLEN(XLEN), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst), .ra(ra), .rb(rb), .qa(qa), .qb(qb),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_ready(wb_ready),
    .stall(stall), .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .init_done(init_done), .rf_ra(rf_ra), .rf_rb(rf_rb), .rf_rd(rf_rd),
    .rf_di(rf_di), .rf_we(rf_we), .rf_qa(rf_qa), .rf_qb(rf_qb)
  );

  always #5 clk = ~clk;

  assign rf_qa = ovr_a ? '1 : mem[rf_ra];
  assign rf_qb = mem[rf_rb];
  always @(posedge clk) if (rf_we) mem[rf_rd] <= rf_di;

  // Architectural model: what the registers should hold and where the
  // controller is in its sweep / debug handshake.
  logic [XLEN-1:0] arch [32];
  bit              m_init, m_dbg, m_done, last_ack;
  int              m_ic, m_starve;
  logic [XLEN-1:0] m_rdata;
  int              n_checks = 0;
  int              n_fail   = 0;

  task automatic chk(input string tag, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_checks++;
    assert (act === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_init = 1; m_ic = 0; m_dbg = 0; m_starve = 0; m_done = 0; m_rdata = '0;
  endtask

  // Called just after a rising edge with inputs already applied.
  task automatic step(input bit qchk);
    bit              grant, dgw, dgr, e_stall, e_wbr, e_we;
    logic [4:0]      e_rd, e_rb;
    logic [XLEN-1:0] e_di, e_qa, e_qb, rd_val;
    @(negedge clk);
    grant = 0; dgw = 0; dgr = 0; e_rb = rb;
    if (m_init) begin
      e_stall = 1; e_wbr = 0; e_we = 1; e_rd = 5'(m_ic); e_di = '0;
    end else begin
      grant   = !m_dbg && dbg_req && (!wb_valid || m_starve == LIMIT);
      dgw     = grant && dbg_we;
      dgr     = grant && !dbg_we;
      e_stall = grant;
      e_wbr   = wb_valid && !dgw;
      if (dgr) e_rb = dbg_addr;
      e_rd = dgw ? dbg_addr : wb_rd;
      e_di = dgw ? dbg_wdata : wb_data;
      e_we = (dgw || e_wbr) && e_rd != 0;
    end
    rd_val = (dbg_addr == 0) ? '0 : arch[dbg_addr];
    chk("stall", 32'(stall), 32'(e_stall));
    chk("wb_ready", 32'(wb_ready), 32'(e_wbr));
    chk("dbg_ack", 32'(dbg_ack), 32'(m_dbg));
    chk("init_done", 32'(init_done), 32'(m_done));
    chk("rf_we", 32'(rf_we), 32'(e_we));
    chk("rf_ra", 32'(rf_ra), 32'(ra));
    chk("rf_rb", 32'(rf_rb), 32'(e_rb));
    if (e_we) begin
      chk("rf_rd", 32'(rf_rd), 32'(e_rd));
      chk("rf_di", rf_di, e_di);
    end
    if (m_dbg) chk("dbg_rdata", dbg_rdata, m_rdata);
    if (qchk && !m_init) begin
      e_qa = (ra == 0) ? '0 : (e_we && e_rd == ra) ? e_di : (ovr_a ? '1 : arch[ra]);
      e_qb = (rb == 0) ? '0 : (e_we && e_rd == rb) ? e_di : arch[rb];
      chk("qa", qa, e_qa);
      if (!dgr) chk("qb", qb, e_qb);
    end
    last_ack = m_dbg;
    @(posedge clk);
    if (m_init) begin
      arch[m_ic] = '0;
      if (m_ic == 31) begin m_init = 0; m_done = 1; end
      else m_ic++;
    end else begin
      if (e_we) arch[e_rd] = e_di;
      if (dgr) m_rdata = rd_val;
      if (grant) m_starve = 0;
      else if (!m_dbg && dbg_req && m_starve < LIMIT) m_starve++;
      m_dbg = grant;
    end
    #1;
  endtask

  task automatic idle();
    wb_valid = 0; wb_rd = '0; wb_data = '0; dbg_req = 0; dbg_we = 0;
    dbg_addr = '0; dbg_wdata = '0; ra = '0; rb = '0; ovr_a = 0;
  endtask

  initial begin
    idle();
    for (int i = 0; i < 32; i++) arch[i] = 32'hBAD0_0000 | 32'(i);
    model_reset();
    #2;
    chk("rst_stall", 32'(stall), 32'd1);
    chk("rst_wb_ready", 32'(wb_ready), 32'd0);
    chk("rst_dbg_ack", 32'(dbg_ack), 32'd0);
    chk("rst_rdata", dbg_rdata, '0);
    @(posedge clk); #1 rst = 1;

    // Sweep; writeback requests must be ignored.
    for (int i = 0; i < 32; i++) begin
      wb_valid = 1'($urandom); wb_rd = 5'($urandom); wb_data = $urandom;
      step(0);
    end
    idle();
    step(1);

    // Writeback with same-cycle forwarding, then read back through the array.
    wb_valid = 1; wb_rd = 5; wb_data = 32'hDEADBEEF; ra = 5;
    step(1);
    chk("fwd_const", qa, 32'hDEADBEEF);
    wb_valid = 0;
    #1 chk("stored_const", qa, 32'hDEADBEEF);
    step(1);

    // x0 writes accepted but dropped; x0 reads masked.
    wb_valid = 1; wb_rd = 0; wb_data = 32'h1234; ra = 0; ovr_a = 1;
    #1 chk("x0_we", 32'(rf_we), 32'd0);
    step(1);
    idle();

    // Debug read of x7.
    wb_valid = 1; wb_rd = 7; wb_data = 32'hA5A5A5A5;
    step(1);
    idle();
    dbg_req = 1; dbg_we = 0; dbg_addr = 7;
    step(1);
    step(1);
    chk("dbg_rd_const", dbg_rdata, 32'hA5A5A5A5);
    idle();
    step(1);

    // Starvation: debug write to x3 under constant writeback pressure.
    wb_valid = 1; wb_rd = 9; dbg_req = 1; dbg_we = 1; dbg_addr = 3; dbg_wdata = 32'h55;
    for (int i = 0; i < 6; i++) begin
      wb_data = $urandom;
      step(1);
    end
    chk("starve_acked", 32'(last_ack), 32'd1);
    idle();
    rb = 3;
    step(1);

    // Random traffic with debug requests held until acknowledged.
    for (int i = 0; i < 600; i++) begin
      if (last_ack) dbg_req = 0;
      else if (!dbg_req && $urandom_range(0, 3) == 0) begin
        dbg_req = 1; dbg_we = 1'($urandom); dbg_addr = 5'($urandom); dbg_wdata = $urandom;
      end
      wb_valid  = (i < 300) ? ($urandom_range(0, 9) < 9) : 1'($urandom);
      wb_rd     = 5'($urandom);
      wb_data   = $urandom;
      ra        = 5'($urandom);
      rb        = 5'($urandom);
      step(1);
    end
    idle();
    step(1);

    // Reset in the middle of a debug grant.
    dbg_req = 1; dbg_we = 0; dbg_addr = 7;
    #2;
    chk("mid_grant_stall", 32'(stall), 32'd1);
    chk("mid_grant_rb", 32'(rf_rb), 32'd7);
    rst = 0;
    #1;
    chk("mid_rst_ack", 32'(dbg_ack), 32'd0);
    chk("mid_rst_stall", 32'(stall), 32'd1);
    chk("mid_rst_done", 32'(init_done), 32'd0);
    chk("mid_rst_wb_ready", 32'(wb_ready), 32'd0);
    chk("mid_rst_rdata", dbg_rdata, '0);
    chk("mid_rst_rd", 32'(rf_rd), 32'd0);
    model_reset();
    @(posedge clk); #1;
    rst = 1; dbg_req = 0;
    for (int i = 0; i < 32; i++) step(0);
    for (int i = 0; i < 4; i++) begin
      ra = 5'($urandom); rb = 5'($urandom);
      step(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
